// File: rtl/ks64_seq_if.sv
// ks64_seq_if
// Handshake bundle between a 64x64 GF(2) multiplier and its client.
//   in_valid / in_ready / a / b     : operand transfer (client -> multiplier)
//   out_valid / out_ready / d       : product transfer (multiplier -> client)
//   busy                            : multiplier is not idle
// Modports: master = client side, slave = multiplier side.
interface ks64_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         out_valid;
    logic         out_ready;
    logic [126:0] d;
    logic         busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, d, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, d, busy
    );
endinterface

// File: rtl/ks64_seq.sv
// ks64_seq
// Sequential 64x64 carry-less (GF(2)[x]) multiplier. One ks32 Karatsuba core
// is time-shared over three cycles (low halves, high halves, half sums) and
// the three partial products are recombined with XOR into a 127-bit product.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : ks64_seq_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/d, busy)
//
// Build option: KS64_SEQ_PIPE_EN registers the ks32 output and adds a FLUSH
// state, making latency 4 instead of 3 cycles.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// LO    | core fed with low halves (m2)
// HI    | core fed with high halves (m1)
// MID   | core fed with half sums (m3)
// FLUSH | pipelined build only: m3 in flight through the core register
// DONE  | product held in d, out_valid high until accepted

// ks32: combinational 32x32 carry-less multiply, one Karatsuba level over
// 16x16 schoolbook partial products.
module ks32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [62:0] p
);
    function automatic logic [30:0] clmul16(input logic [15:0] u, input logic [15:0] v);
        logic [30:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = r ^ ({15'b0, u} << i);
        end
        return r;
    endfunction

    logic [30:0] p_lo;
    logic [30:0] p_hi;
    logic [30:0] p_mid;
    logic [30:0] p_cross;

    always_comb begin
        p_lo    = clmul16(x[15:0], y[15:0]);
        p_hi    = clmul16(x[31:16], y[31:16]);
        p_mid   = clmul16(x[31:16] ^ x[15:0], y[31:16] ^ y[15:0]);
        p_cross = p_mid ^ p_lo ^ p_hi;
        p       = {p_hi, 32'b0} ^ {16'b0, p_cross, 16'b0} ^ {32'b0, p_lo};
    end
endmodule

module ks64_seq (
    input  logic        clk,
    input  logic        rst_n,
    ks64_seq_if.slave   bus
);
`ifdef KS64_SEQ_PIPE_EN
    typedef enum logic [2:0] {IDLE, LO, HI, MID, FLUSH, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LO, HI, MID, DONE} state_t;
`endif

    state_t        state;
    logic [63:0]   ar;
    logic [63:0]   br;
    logic [62:0]   m1;
    logic [62:0]   m2;
    logic [126:0]  d_q;
    logic [31:0]   core_x;
    logic [31:0]   core_y;
    logic [62:0]   core_p;

    // Karatsuba recombination: hi<<64 ^ (hi^lo^mid)<<32 ^ lo.
    function automatic logic [126:0] recomb(input logic [62:0] hi,
                                            input logic [62:0] lo,
                                            input logic [62:0] mid);
        logic [62:0] t;
        t = hi ^ lo ^ mid;
        return {hi, 64'b0} ^ {32'b0, t, 32'b0} ^ {64'b0, lo};
    endfunction

    always_comb begin
        core_x = '0;
        core_y = '0;
        case (state)
            LO: begin
                core_x = ar[31:0];
                core_y = br[31:0];
            end
            HI: begin
                core_x = ar[63:32];
                core_y = br[63:32];
            end
            MID: begin
                core_x = ar[63:32] ^ ar[31:0];
                core_y = br[63:32] ^ br[31:0];
            end
            default: begin
                core_x = '0;
                core_y = '0;
            end
        endcase
    end

    ks32 u_core (
        .x (core_x),
        .y (core_y),
        .p (core_p)
    );

`ifdef KS64_SEQ_PIPE_EN
    // Each core product appears here one cycle after its operands were issued.
    logic [62:0] core_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) core_q <= '0;
        else        core_q <= core_p;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ar    <= '0;
            br    <= '0;
            m1    <= '0;
            m2    <= '0;
            d_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        ar    <= bus.a;
                        br    <= bus.b;
                        state <= LO;
                    end
                end
`ifdef KS64_SEQ_PIPE_EN
                LO: state <= HI;
                HI: begin
                    m2    <= core_q;
                    state <= MID;
                end
                MID: begin
                    m1    <= core_q;
                    state <= FLUSH;
                end
                FLUSH: begin
                    d_q   <= recomb(m1, m2, core_q);
                    state <= DONE;
                end
`else
                LO: begin
                    m2    <= core_p;
                    state <= HI;
                end
                HI: begin
                    m1    <= core_p;
                    state <= MID;
                end
                MID: begin
                    d_q   <= recomb(m1, m2, core_p);
                    state <= DONE;
                end
`endif
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.d         = d_q;
endmodule

// File: tb/tb_ks64_seq.sv
module tb_ks64_seq;
`ifdef KS64_SEQ_PIPE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ks64_seq_if bus ();

    ks64_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [126:0] d;
        string        name;
    } vec_t;

    vec_t vecs[5];

    // Schoolbook carry-less product.
    function automatic logic [126:0] clmul64(input logic [63:0] x, input logic [63:0] y);
        logic [126:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (y[i]) r = r ^ ({63'b0, x} << i);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [126:0] act, input logic [126:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {126'b0, act}, {126'b0, exp});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops;
        bus.a = {$urandom, $urandom};
        bus.b = {$urandom, $urandom};
    endtask

    // Waits (bounded) for out_valid; returns number of edges waited.
    // Optionally drives garbage in_valid while the block is busy.
    task automatic wait_out(input bit noise, output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            if (noise) begin
                bus.in_valid = 1'($urandom);
                rand_ops();
            end
            step();
            n++;
        end
        bus.in_valid = 1'b0;
    endtask

    // One operation with out_ready high; checks latency, product, single-cycle valid.
    task automatic do_op(input logic [63:0] av, input logic [63:0] bv,
                         input logic [126:0] exp, input string name);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        bus.out_ready = 1'b1;
        bus.a = av;
        bus.b = bv;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        rand_ops();
        chk1({name, "_busy"}, bus.busy, 1'b1);
        wait_out(1'b0, n);
        chk({name, "_latency"}, 127'(n), 127'(LAT));
        chk({name, "_d"}, bus.d, exp);
        step();
        chk1({name, "_valid_one_cycle"}, bus.out_valid, 1'b0);
        chk1({name, "_ready_after"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        int          n;
        logic [126:0] exp;
        logic [126:0] held;

        total = 0;
        bad   = 0;

        vecs[0] = '{64'h1, 64'h1, 127'h1, "one"};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    127'h5555_5555_5555_5555_5555_5555_5555_5555, "all_ones"};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    127'h4000_0000_0000_0000_0000_0000_0000_0000, "top_bits"};
        vecs[3] = '{64'h1_0000_0001, 64'h3, 127'h3_0000_0003, "split"};
        vecs[4] = '{64'h2, 64'h3, 127'h6, "small"};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst_n = 1'b0;
        #1;
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk("rst_d", bus.d, '0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();

        // Table vectors.
        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].name);
        end

        // Backpressure: hold out_ready low, poke in_valid, then release.
        bus.out_ready = 1'b0;
        bus.a = 64'hDEAD_BEEF_0123_4567;
        bus.b = 64'h0F0F_1234_8765_F00D;
        exp = clmul64(bus.a, bus.b);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_out(1'b0, n);
        chk("bp_latency", 127'(n), 127'(LAT));
        chk("bp_d", bus.d, exp);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                bus.in_valid = 1'b1;
                bus.a = 64'h7;
                bus.b = 64'h9;
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            chk1("bp_valid_hold", bus.out_valid, 1'b1);
            chk1("bp_ready_low", bus.in_ready, 1'b0);
            chk("bp_d_stable", bus.d, exp);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk1("bp_release_ready", bus.in_ready, 1'b1);
        chk1("bp_release_valid", bus.out_valid, 1'b0);
        chk("bp_d_kept", bus.d, exp);
        do_op(64'h5, 64'h3, 127'hF, "after_bp");

        // Reset in HI discards the operation.
        bus.a = 64'hFFFF_0000_FFFF_0000;
        bus.b = 64'h1234_5678_9ABC_DEF0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk1("midrst_in_ready", bus.in_ready, 1'b1);
        chk1("midrst_busy", bus.busy, 1'b0);
        chk1("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_d", bus.d, '0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        do_op(64'h2, 64'h3, 127'h6, "post_rst");

        // Random operands, random out_ready, noise on in_valid while busy.
        for (int k = 0; k < 1000; k++) begin
            int idle;
            logic [63:0] ra;
            logic [63:0] rb;
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) step();
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (k % 7 == 0) ra = ra & 64'hFFFF_FFFF;
            if (k % 11 == 0) rb = rb & 64'hFFFF_FFFF_0000_0000;
            exp = clmul64(ra, rb);
            bus.a = ra;
            bus.b = rb;
            bus.out_ready = 1'($urandom);
            bus.in_valid = 1'b1;
            step();
            wait_out(1'b1, n);
            chk("rnd_latency", 127'(n), 127'(LAT));
            chk("rnd_d", bus.d, exp);
            held = bus.d;
            n = 0;
            do begin
                bus.out_ready = 1'($urandom);
                step();
                n++;
                if (bus.out_valid) chk("rnd_d_stable", bus.d, held);
            end while (bus.out_valid && n < 30);
            chk1("rnd_handshake", bus.out_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ks64_seq.md
# ks64_seq

Sequential 64x64 binary-polynomial (GF(2)[x]) multiplier that time-shares one `ks32` Karatsuba core over three cycles per operation. It sits one level above `ks32` in the multiplier hierarchy and is the building block for wider Toom/Karatsuba schedulers. The top-level Karatsuba recombination is sequenced here rather than built as three parallel 32-bit cores. Valid/ready handshakes on input and output.

## Interface

Parameters:
- none. Widths are fixed at 64-bit operands and a 127-bit product.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operands `a`/`b` valid
- `in_ready`  out  1  block can accept operands
- `a`  in  64  operand A; bit i is the coefficient of x^i
- `b`  in  64  operand B
- `out_valid`  out  1  product `d` valid
- `out_ready`  in  1  consumer accepts `d`
- `d`  out  127  product A·B over GF(2), registered
- `busy`  out  1  high whenever the state is not IDLE

## Operation

- One clock; reset is asynchronous and active-low.
- Single shared `ks32` instance. Its operands are muxed by state:
  - LO: `a[31:0]`, `b[31:0]` -> m2
  - HI: `a[63:32]`, `b[63:32]` -> m1
  - MID: `a[63:32]^a[31:0]`, `b[63:32]^b[31:0]` -> m3
- The operands are captured into 64-bit registers `ar`/`br` when `in_valid && in_ready`.
- m2 and m1 are held in 63-bit registers. m3 is used directly from the core.
- Recombination, XOR only, no carries:
  - `d = (m1 << 64) ^ ((m1 ^ m2 ^ m3) << 32) ^ m2`
  - The middle term is 63 bits wide and covers bits 32..94. m1 covers bits 64..126. m2 covers bits 0..62.
- States and transitions:
  - IDLE -> LO on an input handshake.
  - LO -> HI -> MID, unconditionally.
  - MID -> DONE; `d` is registered on this transition.
  - DONE -> IDLE on `out_valid && out_ready`.
- `in_ready` = (state == IDLE). It is combinational from state.
- `out_valid` = (state == DONE).
- `busy` = (state != IDLE).
- No new operands are accepted in LO, HI, MID or DONE. `in_valid` is ignored in those states.
- `d` is stable for the whole time `out_valid` is high. `d` keeps its last value after the output handshake until the next MID->DONE transition.
- Reset, including mid-operation:
  - state = IDLE; `ar`, `br`, m1, m2 and `d` = 0; `out_valid` = 0; `busy` = 0.
  - `in_ready` reads 1 while in reset. No capture occurs because the flops are held.
  - Any in-flight operation is discarded.

## Timing

- Input handshake at rising edge N. Without `KS64_SEQ_PIPE_EN`:
  - m2 is latched at N+1 and m1 at N+2.
  - `d` is latched at N+3, and `out_valid` rises after N+3.
  - Latency is 3 cycles.
- Output handshake at edge M: `in_ready` is high after M. The next input handshake can be at M+1 at the earliest.
- Maximum throughput is one product per 5 cycles, with `out_ready` tied high.
- The `ks32` path is combinational: operand mux -> `ks32` -> XOR tree -> `d` register. In the default build this is the critical path.

## Configuration

- `KS64_SEQ_PIPE_EN` defined:
  - A 63-bit register is inserted on the `ks32` output.
  - The FSM adds a FLUSH state between MID and DONE. Core operands are still issued in LO/HI/MID, and each product lands one cycle later.
  - `d` is latched at N+4, so latency is 4 cycles and throughput is one product per 6 cycles.
  - The handshake rules are unchanged.
- Not defined: no output register and no FLUSH state. Latency is 3 cycles, as above.

## Test plan

- `a=1`, `b=1`, `out_ready=1`:
  - `d=1`.
  - `out_valid` is high exactly one cycle, 3 edges after the accept (4 with the macro).
- `a=b=64'hFFFF_FFFF_FFFF_FFFF`:
  - `d` has every even bit 0..126 set and every odd bit clear, i.e. `127'h5555_5555_5555_5555_5555_5555_5555_5555`.
- `a=b=1<<63`: `d=1<<126`.
- `a=64'h1_0000_0001`, `b=64'h3`: `d=127'h3_0000_0003`.
- Backpressure:
  - Hold `out_ready=0` for 10 cycles after `out_valid` rises. `d` stays stable, `out_valid` stays high, and `in_ready` stays 0.
  - A new `in_valid` pulse during this window is ignored.
  - After `out_ready` is released, the next accept is at M+1 at the earliest.
- Reset and random check:
  - Assert `rst_n=0` while in HI: all outputs return to reset values immediately.
  - After release, a fresh operation (`a=2`, `b=3` -> `d=6`) completes correctly.
  - Run 1000 random operand pairs with random `out_ready` against a software carry-less multiply model, in both macro builds.
